// File: rtl/gpif_sched_pkg.sv
// Shared types for the slave-FIFO burst scheduler:
// state encoding and SL_AD socket codes.
package gpif_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD,
        ST_RDWAIT,
        ST_WR,
        ST_PKTEND,
        ST_TURN
    } state_t;

    localparam logic [1:0] AD_CU2F = 2'b00;
    localparam logic [1:0] AD_DU2F = 2'b01;
    localparam logic [1:0] AD_DF2U = 2'b10;

endpackage

// File: rtl/gpif_sched_if.sv
// Slave-FIFO pins plus local FIFO level/strobe bundle
// shared by the scheduler (master) and its environment (slave).
interface gpif_sched_if #(
    parameter int CNTW = 11
);

    logic            SL_FLAGA;
    logic            SL_FLAGB;
    logic            SL_FLAGC;
    logic [1:0]      SL_AD;
    logic            SL_RD_N;
    logic            SL_OE_N;
    logic            SL_WR_N;
    logic            SL_PKTEND_N;
    logic            SL_DT_OE;
    logic [CNTW-1:0] cu2f_room;
    logic [CNTW-1:0] du2f_room;
    logic [CNTW-1:0] df2u_items;
    logic            cu2f_we;
    logic            du2f_we;
    logic            df2u_re;
    logic            busy;

    modport master (
        input  SL_FLAGA, SL_FLAGB, SL_FLAGC,
        input  cu2f_room, du2f_room, df2u_items,
        output SL_AD, SL_RD_N, SL_OE_N, SL_WR_N,
        output SL_PKTEND_N, SL_DT_OE,
        output cu2f_we, du2f_we, df2u_re, busy
    );

    modport slave (
        output SL_FLAGA, SL_FLAGB, SL_FLAGC,
        output cu2f_room, du2f_room, df2u_items,
        input  SL_AD, SL_RD_N, SL_OE_N, SL_WR_N,
        input  SL_PKTEND_N, SL_DT_OE,
        input  cu2f_we, du2f_we, df2u_re, busy
    );

endinterface

// File: rtl/gpif_sched.sv
// Slave-FIFO burst scheduler: arbitrates command/data sockets,
// sequences read and write bursts, flushes short writes on timeout.
module gpif_sched
    import gpif_sched_pkg::*;
#(
    parameter int BURST    = 16,
    parameter int RD_LAT   = 2,
    parameter int FLAG_LAT = 3,
    parameter int TIMEOUT  = 1024,
    parameter int CNTW     = 11
) (
    input  logic         SYS_CLK,
    input  logic         SYS_RST_N,
    gpif_sched_if.master bus
);

    localparam int CW = CNTW + 2;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            st_q, st_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        ad_q, ad_d;
    logic [CW-1:0]     len_q, len_d;
    logic              rr_q, rr_d;
    logic [2:0]        flg_q;
    logic [TW-1:0]     to_q, to_d;
    logic [RD_LAT-1:0] rdp_q;

    logic [CW-1:0] burst_c;
    logic [CW-1:0] items_w;
    logic          expired;
    logic          cmd_ok;
    logic          du_ok;
    logic          df_ok;
    logic          rd_act;
    logic          we_tap;

    assign burst_c = CW'(BURST);
    assign items_w = CW'(bus.df2u_items);
    assign expired = (to_q == TW'(TIMEOUT));

    assign cmd_ok = flg_q[0] && (CW'(bus.cu2f_room) >= burst_c);
    assign du_ok  = flg_q[1] && (CW'(bus.du2f_room) >= burst_c);
    assign df_ok  = flg_q[2] &&
                    ((items_w >= burst_c) ||
                     ((items_w != '0) && expired));

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q + CW'(1);
        ad_d  = ad_q;
        len_d = len_q;
        rr_d  = rr_q;
        unique case (st_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_ok) begin
                    ad_d = AD_CU2F;
                    st_d = ST_ADDR;
                end else if (du_ok && (!df_ok || !rr_q)) begin
                    ad_d = AD_DU2F;
                    rr_d = ~rr_q;
                    st_d = ST_ADDR;
                end else if (df_ok) begin
                    ad_d  = AD_DF2U;
                    rr_d  = ~rr_q;
                    len_d = (items_w >= burst_c) ? burst_c : items_w;
                    st_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d = '0;
                    st_d  = (ad_q == AD_DF2U) ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_q == CW'(BURST - 1)) begin
                    cnt_d = '0;
                    st_d  = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    cnt_d = '0;
                    st_d  = ST_TURN;
                end
            end
            // Strobe phase is len cycles, plus one for the trailing
            // WR_N and one for the data hold after it.
            ST_WR: begin
                if (cnt_q == len_q + CW'(1)) begin
                    cnt_d = '0;
                    st_d  = (len_q < burst_c) ? ST_PKTEND : ST_TURN;
                end
            end
            ST_PKTEND: begin
                cnt_d = '0;
                st_d  = ST_TURN;
            end
            ST_TURN: begin
                if (cnt_q == CW'(FLAG_LAT)) begin
                    cnt_d = '0;
                    st_d  = ST_IDLE;
                end
            end
            default: begin
                cnt_d = '0;
                st_d  = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        to_d = to_q;
        if (bus.df2u_items == '0) begin
            to_d = '0;
        end else if ((st_q == ST_ADDR) && (st_d == ST_WR)) begin
            to_d = '0;
        end else if ((st_q != ST_WR) && !expired) begin
            to_d = to_q + TW'(1);
        end
    end

    assign rd_act = (st_q == ST_RD);

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
            ad_q  <= AD_CU2F;
            len_q <= '0;
            rr_q  <= 1'b0;
            flg_q <= '0;
            to_q  <= '0;
            rdp_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            ad_q  <= ad_d;
            len_q <= len_d;
            rr_q  <= rr_d;
            flg_q <= {bus.SL_FLAGC, bus.SL_FLAGB, bus.SL_FLAGA};
            to_q  <= to_d;
            rdp_q <= (rdp_q << 1) | RD_LAT'(rd_act);
        end
    end

    // Read data lands RD_LAT cycles after each RD_N low.
    assign we_tap = rdp_q[RD_LAT-1];

    assign bus.SL_AD = (st_q == ST_IDLE)
                     ? ((st_d == ST_ADDR) ? ad_d : AD_CU2F)
                     : ad_q;

    assign bus.SL_RD_N = !rd_act;
    assign bus.SL_OE_N = !(((st_q == ST_ADDR) && (cnt_q == CW'(1)) &&
                            (ad_q != AD_DF2U)) ||
                           (st_q == ST_RD) || (st_q == ST_RDWAIT));
    assign bus.SL_WR_N = !((st_q == ST_WR) && (cnt_q != '0) &&
                           (cnt_q <= len_q));
    assign bus.SL_PKTEND_N = (st_q != ST_PKTEND);
    assign bus.SL_DT_OE    = (st_q == ST_WR);

    assign bus.cu2f_we = we_tap && (ad_q == AD_CU2F);
    assign bus.du2f_we = we_tap && (ad_q == AD_DU2F);
    assign bus.df2u_re = (st_q == ST_WR) && (cnt_q < len_q);
    assign bus.busy    = (st_q != ST_IDLE);

endmodule

// File: doc/gpif_sched.md
GPIF_SCHED -- requirements
Module: gpif_sched

Interface
REQ-001 SHALL have parameter BURST, default 16: words per slave-FIFO burst.
REQ-002 SHALL have parameter RD_LAT, default 2: cycles from SL_RD_N low to valid SL_DT.
REQ-003 SHALL have parameter FLAG_LAT, default 3: cycles after the last strobe before flags are valid.
REQ-004 SHALL have parameter TIMEOUT, default 1024: cycles before a short F2U write is flushed.
REQ-005 SHALL have parameter CNTW, default 11: width of the FIFO level inputs.
REQ-006 SHALL have port SYS_CLK, input, 1 bit: single clock; all ports are synchronous to it.
REQ-007 SHALL have port SYS_RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have ports SL_FLAGA, SL_FLAGB and SL_FLAGC, inputs, 1 bit each: command-U2F socket non-empty; data-U2F socket non-empty; data-F2U socket has room for BURST words.
REQ-009 SHALL have port SL_AD, output, 2 bits: socket select; 00 = command-U2F, 01 = data-U2F, 10 = data-F2U.
REQ-010 SHALL have ports SL_RD_N, SL_OE_N, SL_WR_N and SL_PKTEND_N, outputs, 1 bit each, active-low slave-FIFO strobes.
REQ-011 SHALL have port SL_DT_OE, output, 1 bit: enables the FPGA drivers on SL_DT.
REQ-012 SHALL have ports cu2f_room and du2f_room, inputs, CNTW bits each: free entries in the CU2F and DU2F FIFOs.
REQ-013 SHALL have port df2u_items, input, CNTW bits: words held in the DF2U FIFO.
REQ-014 SHALL have ports cu2f_we and du2f_we, outputs, 1 bit each: one pulse writes one received word.
REQ-015 SHALL have port df2u_re, output, 1 bit: one pulse pops one word for transmit.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 SHALL register SL_FLAGA to SL_FLAGC once; all decisions use the registered copies.
REQ-018 SHALL implement states IDLE, ADDR, RD, RDWAIT, WR, PKTEND and TURN.
REQ-019 SHALL define eligibility in IDLE:
- cmd = FLAGA and cu2f_room>=BURST.
- du2f = FLAGB and du2f_room>=BURST.
- df2u = FLAGC and (df2u_items>=BURST, or df2u_items>0 with the timeout expired).
REQ-020 SHALL arbitrate as follows:
- cmd has strict priority.
- du2f and df2u share round-robin; the pointer starts at du2f and toggles only on a data grant.
REQ-021 SHALL, on a grant, drive SL_AD, latch the selection and go to ADDR; for a write it also latches len = min(df2u_items, BURST).
REQ-022 SHALL hold ADDR for 2 cycles; for reads SL_OE_N goes low in the 2nd ADDR cycle and stays low through the end of RDWAIT.
REQ-023 SHALL hold SL_RD_N low for exactly BURST consecutive cycles in RD, then spend RD_LAT cycles in RDWAIT.
REQ-024 SHALL produce the selected cu2f_we or du2f_we as the SL_RD_N-low sequence delayed by RD_LAT cycles, giving exactly BURST pulses.
REQ-025 SHALL, in WR:
- Pulse df2u_re for len consecutive cycles.
- Drive SL_WR_N low for len cycles, each one cycle after the matching df2u_re.
- Hold SL_DT_OE high from WR entry until one cycle after the last SL_WR_N low.
REQ-026 SHALL, when len<BURST, go to PKTEND with SL_PKTEND_N low for 1 cycle; otherwise go directly to TURN.
REQ-027 SHALL hold TURN for FLAG_LAT+1 cycles with all strobes high and SL_DT_OE low, then return to IDLE.
REQ-028 SHALL run a timeout counter as follows:
- Increments each cycle while df2u_items>0 and the state is not WR.
- Clears on WR entry or when df2u_items==0.
- Saturates at TIMEOUT; "expired" means counter==TIMEOUT.
REQ-029 SHALL treat these boundaries as follows:
- room==BURST is eligible; room==BURST-1 is not.
- df2u_items==0 never writes.
- Flag changes during RD, WR or TURN are ignored.
- SL_RD_N and SL_WR_N are never low in the same cycle.

Reset
REQ-030 SHALL, on SYS_RST_N low, immediately and asynchronously:
- Drive SL_AD=00, all *_N high, SL_DT_OE=0, cu2f_we=du2f_we=df2u_re=0 and busy=0.
- Set state IDLE, round-robin pointer to du2f, timeout counter 0 and flag registers 0.
REQ-031 SHALL, on reset during a burst, abandon the burst; any words not yet transferred are lost and no further we/re pulses are issued.

Structure
REQ-032 SHALL place the state encoding and the SL_AD socket codes in shared package gpif_sched_pkg.
REQ-033 SHALL implement the arbiter, state machine, burst counter and timeout counter in one module with no sub-module.

Verification
REQ-034 SHALL cover: reset released, flags 0 for 100 cycles -> all strobes high, SL_AD=00, busy=0.
REQ-035 SHALL cover: FLAGA=1, cu2f_room=16 -> SL_AD=00; SL_RD_N low 16 cycles; 16 cu2f_we pulses starting 2 cycles after the first SL_RD_N low; then TURN for 4 cycles.
REQ-036 SHALL cover: cu2f_room=15 with FLAGA=1 -> no read; room raised to 16 -> read starts.
REQ-037 SHALL cover: FLAGB=FLAGC=1, du2f_room=64, df2u_items=64 -> grants alternate du2f, df2u, du2f; with FLAGA=1 as well, cmd is granted first every time.
REQ-038 SHALL cover: FLAGC=1, df2u_items=5 -> no write for 1024 cycles; then 5 df2u_re pulses, 5 SL_WR_N lows and 1 SL_PKTEND_N pulse.
REQ-039 SHALL cover: SYS_RST_N low in RD cycle 8 -> all outputs at reset values in the same cycle; no further we pulses after release until a new grant.
